// File: rtl/key_event_scheduler.sv
// Per-frame key scanner: converts the held-key level vector into press/release/repeat
// events queued in a small FIFO and consumed over a valid/ready handshake.
module key_event_scheduler #(
    parameter int               NKEYS        = 10,
    parameter int               FIFO_DEPTH   = 8,
    parameter int               REPEAT_DELAY = 20,
    parameter int               REPEAT_RATE  = 5,
    parameter logic [NKEYS-1:0] REPEAT_MASK  = 10'b00_0111_0011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic [NKEYS-1:0] key,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [3:0]       evt_code,
    output logic [1:0]       evt_type,
    output logic [NKEYS-1:0] held,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DELAY_V  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_V   = CW'(REPEAT_RATE);
    localparam logic [CW-1:0] CTR_ONE  = CW'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NKEYS - 1);

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_REPEAT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SCAN
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [IW-1:0]     idx;
    logic [NKEYS-1:0]  prev;
    logic              pending;
    logic [CW-1:0]     ctr [NKEYS];

    logic              cur_held;
    logic              cur_prev;
    logic              cur_mask;
    logic [CW-1:0]     cur_ctr;
    logic [CW-1:0]     ctr_next;
    logic              push;
    logic [1:0]        push_type;

    logic [5:0]        mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              pop;
    logic              do_push;
    logic              drop;
    logic [5:0]        head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_tick || pending) next_state = SNAP;
            SNAP:    next_state = SCAN;
            SCAN:    if (idx == LAST_IDX) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A tick arriving while busy (including during SNAP) must not be lost, so set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            held    <= '0;
            prev    <= '0;
            pending <= 1'b0;
        end else begin
            if (state == SNAP) begin
                prev <= held;
                held <= key;
                idx  <= '0;
            end else if (state == SCAN) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            end

            if (frame_tick && (state != IDLE)) begin
                pending <= 1'b1;
            end else if (state == SNAP) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_held  = held[idx];
        cur_prev  = prev[idx];
        cur_mask  = REPEAT_MASK[idx];
        cur_ctr   = ctr[idx];
        ctr_next  = cur_ctr;
        push      = 1'b0;
        push_type = EVT_PRESS;
        if (state == SCAN) begin
            if (cur_held && !cur_prev) begin
                push      = 1'b1;
                push_type = EVT_PRESS;
                if (cur_mask) ctr_next = DELAY_V;
            end else if (!cur_held && cur_prev) begin
                push      = 1'b1;
                push_type = EVT_RELEASE;
                ctr_next  = '0;
            end else if (cur_held && cur_prev && cur_mask) begin
                if (cur_ctr == CTR_ONE) begin
                    push      = 1'b1;
                    push_type = EVT_REPEAT;
                    ctr_next  = RATE_V;
                end else begin
                    ctr_next = cur_ctr - CTR_ONE;
                end
            end
        end
    end

    // Counters advance even when the event itself is dropped on a full queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NKEYS; i++) ctr[i] <= '0;
        end else if (state == SCAN) begin
            ctr[idx] <= ctr_next;
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;
    assign do_push   = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign evt_code  = evt_valid ? head[5:2] : 4'd0;
    assign evt_type  = evt_valid ? head[1:0] : 2'd0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= {4'(idx), push_type};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed testbench for key_event_scheduler: one task per scenario, each with
// its own hand-computed expectations.
module tb_key_event_scheduler;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic [9:0] key;
    logic       evt_ready;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic [1:0] evt_type;
    logic [9:0] held;
    logic       overflow;
    logic       overflow_clr;

    int total;
    int bad;
    int q_code[$];
    int q_type[$];
    int q_tag[$];

    key_event_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .key          (key),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_type     (evt_type),
        .held         (held),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q_code.delete();
        q_type.delete();
        q_tag.delete();
    endtask

    // Records the head event on every sampled cycle where it is being accepted.
    task automatic collect(input int n, input int tag);
        for (int c = 0; c < n; c++) begin
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                q_code.push_back(int'(evt_code));
                q_type.push_back(int'(evt_type));
                q_tag.push_back(tag);
            end
            step(1);
        end
    endtask

    task automatic run_frame(input int tag);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        collect(14, tag);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        frame_tick   = 1'b0;
        key          = '0;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        step(1);
        total++;
        if (evt_valid !== 1'b0 || evt_code !== 4'd0 || evt_type !== 2'd0 ||
            held !== 10'd0 || overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_values: valid=%b code=%0d type=%0d held=%b ovf=%b, want all 0",
                     evt_valid, evt_code, evt_type, held, overflow);
        end
        rst  = 1'b0;
        seen = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            for (int c = 0; c < 14; c++) begin
                if (evt_valid !== 1'b0) seen = 1'b1;
                step(1);
            end
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_frames_valid: evt_valid seen=%b, want 0", seen);
        end
        total++;
        if (held !== 10'd0) begin
            bad++;
            $display("[TB] FAIL idle_frames_held: held=%b, want 0", held);
        end
    endtask

    task automatic test_press_release();
        do_reset();
        key        = 10'b00_0000_0001;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        total++;
        if (evt_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL latency_t1: evt_valid=%b, want 0", evt_valid);
        end
        step(1);
        total++;
        if (evt_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL latency_t2: evt_valid=%b, want 0", evt_valid);
        end
        step(1);
        total++;
        if (evt_valid !== 1'b1 || evt_code !== 4'd0 || evt_type !== 2'd0) begin
            bad++;
            $display("[TB] FAIL latency_t3_press: valid=%b code=%0d type=%0d, want 1/0/0",
                     evt_valid, evt_code, evt_type);
        end
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        step(12);
        total++;
        if (evt_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_press: evt_valid=%b after pop, want 0", evt_valid);
        end
        key = '0;
        clear_q();
        evt_ready = 1'b1;
        run_frame(0);
        evt_ready = 1'b0;
        total++;
        if (q_code.size() != 1 || q_code[0] != 0 || q_type[0] != 1) begin
            bad++;
            $display("[TB] FAIL release_event: count=%0d first code=%0d type=%0d, want 1 event 0/1",
                     q_code.size(), (q_code.size() > 0) ? q_code[0] : -1,
                     (q_type.size() > 0) ? q_type[0] : -1);
        end
    endtask

    task automatic test_repeat();
        int exp_tag[4];
        int exp_code[4];
        int exp_type[4];
        exp_tag  = '{1, 1, 21, 26};
        exp_code = '{3, 4, 4, 4};
        exp_type = '{0, 0, 2, 2};
        do_reset();
        clear_q();
        key       = 10'b00_0001_1000;
        evt_ready = 1'b1;
        for (int n = 1; n <= 30; n++) run_frame(n);
        evt_ready = 1'b0;
        total++;
        if (q_code.size() != 4) begin
            bad++;
            $display("[TB] FAIL repeat_count: events=%0d, want 4", q_code.size());
        end
        for (int i = 0; i < 4 && i < q_code.size(); i++) begin
            total++;
            if (q_tag[i] != exp_tag[i] || q_code[i] != exp_code[i] || q_type[i] != exp_type[i]) begin
                bad++;
                $display("[TB] FAIL repeat_event%0d: tick=%0d code=%0d type=%0d, want tick=%0d code=%0d type=%0d",
                         i, q_tag[i], q_code[i], q_type[i], exp_tag[i], exp_code[i], exp_type[i]);
            end
        end
    endtask

    task automatic test_priority();
        int exp_code[3];
        exp_code = '{2, 5, 9};
        do_reset();
        clear_q();
        key       = 10'b10_0010_0100;
        evt_ready = 1'b1;
        run_frame(0);
        evt_ready = 1'b0;
        total++;
        if (q_code.size() != 3) begin
            bad++;
            $display("[TB] FAIL priority_count: events=%0d, want 3", q_code.size());
        end
        for (int i = 0; i < 3 && i < q_code.size(); i++) begin
            total++;
            if (q_code[i] != exp_code[i] || q_type[i] != 0) begin
                bad++;
                $display("[TB] FAIL priority_order%0d: code=%0d type=%0d, want %0d/0",
                         i, q_code[i], q_type[i], exp_code[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        clear_q();
        key        = '1;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(14);
        total++;
        if (overflow !== 1'b1 || evt_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overflow_set: overflow=%b valid=%b, want 1/1", overflow, evt_valid);
        end
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overflow_clr: overflow=%b, want 0", overflow);
        end
        evt_ready = 1'b1;
        collect(12, 0);
        evt_ready = 1'b0;
        total++;
        if (q_code.size() != 8) begin
            bad++;
            $display("[TB] FAIL overflow_drain_count: events=%0d, want 8", q_code.size());
        end
        for (int i = 0; i < q_code.size() && i < 8; i++) begin
            total++;
            if (q_code[i] != i || q_type[i] != 0) begin
                bad++;
                $display("[TB] FAIL overflow_drain%0d: code=%0d type=%0d, want %0d/0",
                         i, q_code[i], q_type[i], i);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_q();
        key        = '1;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(9);
        evt_ready = 1'b1;
        collect(2, 0);
        evt_ready = 1'b0;
        step(2);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_push_pop_ovf: overflow=%b, want 0", overflow);
        end
        evt_ready = 1'b1;
        collect(12, 0);
        evt_ready = 1'b0;
        total++;
        if (q_code.size() != 10) begin
            bad++;
            $display("[TB] FAIL full_push_pop_count: events=%0d, want 10", q_code.size());
        end
        for (int i = 0; i < q_code.size() && i < 10; i++) begin
            total++;
            if (q_code[i] != i || q_type[i] != 0) begin
                bad++;
                $display("[TB] FAIL full_push_pop%0d: code=%0d type=%0d, want %0d/0",
                         i, q_code[i], q_type[i], i);
            end
        end
    endtask

    task automatic test_pending();
        do_reset();
        clear_q();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(2);
        key = 10'b00_0100_0000;
        step(1);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(13);
        total++;
        if (held !== 10'b00_0100_0000) begin
            bad++;
            $display("[TB] FAIL pending_rescan: held=%b, want 0001000000", held);
        end
        key = '0;
        step(25);
        total++;
        if (held !== 10'b00_0100_0000) begin
            bad++;
            $display("[TB] FAIL pending_once: held=%b, want 0001000000", held);
        end
        evt_ready = 1'b1;
        collect(5, 0);
        evt_ready = 1'b0;
        total++;
        if (q_code.size() != 1 || q_code[0] != 6 || q_type[0] != 0) begin
            bad++;
            $display("[TB] FAIL pending_events: count=%0d first code=%0d, want 1 event code 6 press",
                     q_code.size(), (q_code.size() > 0) ? q_code[0] : -1);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        key        = '1;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(5);
        total++;
        if (evt_valid !== 1'b1 || held !== 10'h3FF) begin
            bad++;
            $display("[TB] FAIL midscan_pre: valid=%b held=%b, want 1/1111111111", evt_valid, held);
        end
        rst = 1'b1;
        #1;
        total++;
        if (evt_valid !== 1'b0 || evt_code !== 4'd0 || evt_type !== 2'd0 ||
            held !== 10'd0 || overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midscan_reset: valid=%b code=%0d type=%0d held=%b ovf=%b, want all 0",
                     evt_valid, evt_code, evt_type, held, overflow);
        end
        step(1);
        rst = 1'b0;
        clear_q();
        evt_ready = 1'b1;
        run_frame(0);
        evt_ready = 1'b0;
        total++;
        if (q_code.size() != 10 || q_code[0] != 0 || q_type[0] != 0) begin
            bad++;
            $display("[TB] FAIL midscan_rescan: count=%0d first code=%0d, want 10 presses from key 0",
                     q_code.size(), (q_code.size() > 0) ? q_code[0] : -1);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        frame_tick   = 1'b0;
        key          = '0;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        test_reset();
        test_press_release();
        test_repeat();
        test_priority();
        test_overflow();
        test_back_to_back();
        test_pending();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
